// File: rtl/wbu_pipe_pkg.sv
// wbu_pipe shared configuration: source-select codes and the queued entry type.
// The entry type matches the default 32-bit data / 5-bit register-index build.
package wbu_pipe_pkg;

  localparam int ARGS_WIDTH = 3;

  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = 3'd0;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_MEM = 3'd1;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = 3'd2;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_CSR = 3'd3;

  typedef struct packed {
    logic        we;
    logic [4:0]  id;
    logic [31:0] data;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with full/empty flags.
// With WBU_FWD_EN it also exposes all slots in age order (oldest first).
module wbu_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
`ifdef WBU_FWD_EN
  ,
  output logic [DEPTH-1:0][WIDTH-1:0] ord_o,
  output logic [DEPTH-1:0]            ord_vld_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= wdata_i;
    end
  end

`ifdef WBU_FWD_EN
  always_comb begin
    ord_o     = '0;
    ord_vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_o[i]     = mem_q[rd_q + PW'(i)];
      ord_vld_o[i] = ((PW+1)'(i) < cnt_q);
    end
  end
`endif

endmodule

// File: rtl/wbu_pipe.sv
// Buffered writeback stage: source mux, entry FIFO, GPR drain, retire counter.
// Optional macro WBU_FWD_EN adds combinational rs1/rs2 forwarding from the queue.
module wbu_pipe
  import wbu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int DEPTH        = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int PC_LINK_OFS  = 4
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_sys_valid,
  output logic                    o_sys_ready,
  input  logic                    i_idu_ctr_reg_wr_en,
  input  logic [ARGS_WIDTH-1:0]   i_idu_ctr_reg_wr_src,
  input  logic [DATA_WIDTH-1:0]   i_ifu_pc,
  input  logic [DATA_WIDTH-1:0]   i_exu_res,
  input  logic [DATA_WIDTH-1:0]   i_lsu_res,
  input  logic [DATA_WIDTH-1:0]   i_csr_res,
  input  logic [REG_ID_WIDTH-1:0] i_gpr_wr_id,
  input  logic                    i_gpr_ready,
  output logic                    o_wbu_gpr_wr_en,
  output logic [REG_ID_WIDTH-1:0] o_wbu_gpr_wr_id,
  output logic [DATA_WIDTH-1:0]   o_wbu_gpr_wr_data,
  output logic                    o_sys_valid,
  output logic [CNT_WIDTH-1:0]    o_wbu_retire_cnt
`ifdef WBU_FWD_EN
  ,
  input  logic [REG_ID_WIDTH-1:0] i_fwd_rs1_id,
  input  logic [REG_ID_WIDTH-1:0] i_fwd_rs2_id,
  output logic                    o_fwd_rs1_hit,
  output logic                    o_fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0]   o_fwd_rs1_data,
  output logic [DATA_WIDTH-1:0]   o_fwd_rs2_data
`endif
);

  localparam int EW = 1 + REG_ID_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic                    we;
    logic [REG_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   data;
  } entry_t;

  entry_t                 push_ent, head;
  logic                   full, empty, push, pop;
  logic [DATA_WIDTH-1:0]  src_data;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_comb begin
    src_data = '0;
    case (i_idu_ctr_reg_wr_src)
      REG_WR_SRC_ALU: src_data = i_exu_res;
      REG_WR_SRC_MEM: src_data = i_lsu_res;
      REG_WR_SRC_PC:  src_data = i_ifu_pc + DATA_WIDTH'(PC_LINK_OFS);
      REG_WR_SRC_CSR: src_data = i_csr_res;
      default:        src_data = '0;
    endcase
  end

  // x0 writes are dropped here so nothing downstream has to special-case them
  assign push_ent.we   = i_idu_ctr_reg_wr_en && (i_gpr_wr_id != '0);
  assign push_ent.id   = i_gpr_wr_id;
  assign push_ent.data = src_data;

  assign o_sys_ready = !full;
  assign push        = i_sys_valid && !full;
  assign pop         = !empty && (i_gpr_ready || !head.we);

`ifdef WBU_FWD_EN
  entry_t [DEPTH-1:0] ord;
  logic   [DEPTH-1:0] ord_vld;
`endif

  wbu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (i_sys_clk),
    .rst_i     (i_sys_rst),
    .push_i    (push),
    .wdata_i   (push_ent),
    .pop_i     (pop),
    .rdata_o   (head),
    .full_o    (full),
    .empty_o   (empty)
`ifdef WBU_FWD_EN
    ,
    .ord_o     (ord),
    .ord_vld_o (ord_vld)
`endif
  );

  assign o_wbu_gpr_wr_en   = !empty && head.we;
  assign o_wbu_gpr_wr_id   = empty ? '0 : head.id;
  assign o_wbu_gpr_wr_data = empty ? '0 : head.data;
  assign o_sys_valid       = pop;
  assign o_wbu_retire_cnt  = cnt_q;

  assign cnt_d = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

`ifdef WBU_FWD_EN
  // Walk oldest to youngest so the last match wins
  always_comb begin
    o_fwd_rs1_hit  = 1'b0;
    o_fwd_rs2_hit  = 1'b0;
    o_fwd_rs1_data = '0;
    o_fwd_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && ord[i].we && i_fwd_rs1_id != '0 &&
          ord[i].id == i_fwd_rs1_id) begin
        o_fwd_rs1_hit  = 1'b1;
        o_fwd_rs1_data = ord[i].data;
      end
      if (ord_vld[i] && ord[i].we && i_fwd_rs2_id != '0 &&
          ord[i].id == i_fwd_rs2_id) begin
        o_fwd_rs2_hit  = 1'b1;
        o_fwd_rs2_data = ord[i].data;
      end
    end
  end
`endif

endmodule

// File: doc/wbu_pipe.md
Name: wbu_pipe

Overview:
- Buffered, parametrised writeback stage. Sits between LSU and the GPR file.
- Selects the writeback value from the ALU, MEM, PC-link or CSR source and queues it in a DEPTH-entry FIFO. Drains entries to the GPR write port under a ready handshake and counts retired instructions.
- Successor to the single-cycle combinational writeback stage: adds a valid/ready input, GPR back-pressure, x0 suppression, a retire counter and optional forwarding.

Parameters:
- DATA_WIDTH, 32, width of PC and all data paths.
- REG_ID_WIDTH, 5, GPR index width.
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- CNT_WIDTH, 32, retire-counter width.
- PC_LINK_OFS, 4, offset added to the PC for the PC source.

Ports:
- i_sys_clk  in  1  clock
- i_sys_rst  in  1  synchronous active-high reset
- i_sys_valid  in  1  upstream instruction valid
- o_sys_ready  out  1  stage can accept an instruction
- i_idu_ctr_reg_wr_en  in  1  instruction writes a GPR
- i_idu_ctr_reg_wr_src  in  ARGS_WIDTH  source select (REG_WR_SRC_*)
- i_ifu_pc  in  DATA_WIDTH  instruction PC
- i_exu_res  in  DATA_WIDTH  ALU result
- i_lsu_res  in  DATA_WIDTH  load result
- i_csr_res  in  DATA_WIDTH  CSR read value
- i_gpr_wr_id  in  REG_ID_WIDTH  destination register
- i_gpr_ready  in  1  GPR port accepts a write this cycle
- o_wbu_gpr_wr_en  out  1  GPR write strobe
- o_wbu_gpr_wr_id  out  REG_ID_WIDTH  GPR write index
- o_wbu_gpr_wr_data  out  DATA_WIDTH  GPR write data
- o_sys_valid  out  1  one-cycle pulse per retired instruction
- o_wbu_retire_cnt  out  CNT_WIDTH  retired-instruction count
- (WBU_FWD_EN only) i_fwd_rs1_id, i_fwd_rs2_id  in  REG_ID_WIDTH;  o_fwd_rs1_hit, o_fwd_rs2_hit  out  1;  o_fwd_rs1_data, o_fwd_rs2_data  out  DATA_WIDTH

Behaviour:
- Clock i_sys_clk; reset i_sys_rst is synchronous and active-high.
- Reset: FIFO emptied, pointers 0, counter 0. All outputs 0 except o_sys_ready, which is 1.
- Reset mid-operation flushes every queued entry without writing it. Reset takes priority over push, pop and count in the same cycle.
- Source mux at push:
  - ALU -> i_exu_res
  - MEM -> i_lsu_res
  - PC -> i_ifu_pc + PC_LINK_OFS, modulo 2^DATA_WIDTH
  - CSR -> i_csr_res
  - any other code -> 0
- Stored per entry: we, id, data. we = i_idu_ctr_reg_wr_en && (i_gpr_wr_id != 0), so x0 writes are suppressed at push.
- Push when i_sys_valid && o_sys_ready.
- o_sys_ready = !full. It depends only on state, not on same-cycle pop, so a full FIFO does not accept even while popping.
- Latency: an instruction pushed in cycle N is at the head in cycle N+1 if the FIFO was empty.
- Head outputs:
  - o_wbu_gpr_wr_en = !empty && head.we.
  - id and data are driven from the head whenever non-empty, else 0.
- Pop condition: !empty && (i_gpr_ready || !head.we). Non-writing entries retire in one cycle regardless of i_gpr_ready.
- o_sys_valid is combinational and equals the pop condition.
- Counter increments by 1 on each pop and wraps to 0 after 2^CNT_WIDTH-1.
- Simultaneous push and pop with non-full, non-empty FIFO: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Stalls: i_gpr_ready low holds the head stable; outputs do not change while stalled.

Optional Feature:
- Macro WBU_FWD_EN.
- Defined: the forwarding ports exist. For each rsN, hit = 1 if any valid entry with we=1 matches id; data comes from the youngest matching entry. id 0 never hits. Purely combinational.
- Undefined: the ports and logic are absent; the port list is exactly the list above without them.

Decomposition:
- Shared cfg package/header holds ARGS_WIDTH, REG_WR_SRC_ALU/MEM/PC/CSR codes, and a wbu_entry_t struct {we, id, data}.
- One sub-module: wbu_fifo, a generic DEPTH x width synchronous FIFO with full/empty outputs. wbu_pipe instantiates it and adds the mux, retire logic, counter and forwarding.

Test Plan:
- Source select: pc=0x8000_0000, exu=0x1, lsu=0x2, csr=0x3, id=1, i_gpr_ready=1, one instruction per source ALU/MEM/PC/CSR -> data 0x1, 0x2, 0x8000_0004, 0x3, each one cycle after push; counter ends at 4.
- x0 and no-write: id=0 with wr_en=1, then id=3 with wr_en=0 -> o_wbu_gpr_wr_en never 1; two o_sys_valid pulses; counter reaches 2 even with i_gpr_ready=0.
- Back-pressure: i_gpr_ready=0, push 3 ALU writes -> o_sys_ready drops after 2 pushes and the third is held. Raise ready -> writes appear in order, one per cycle.
- Reset mid-stream: 2 entries queued, assert i_sys_rst one cycle -> FIFO empty, o_wbu_gpr_wr_en=0, counter 0, ready 1, and neither queued write appears.
- Counter wrap (CNT_WIDTH=4): 17 retires -> count reads 1.
- WBU_FWD_EN: queue id=5 data 0xA then id=5 data 0xB under stall, query rs1=5, rs2=0 -> rs1 hit with 0xB, rs2 no hit.
